// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the requesters, the round-robin arbiter and one shared uart_tx.
// master = arbiter side, slave = requesters plus uart_tx side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic                 ack_err;
  logic                 busy;
  logic [IDX_W-1:0]     grant_id;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_done;

  modport master (
    input  req, req_data, tx_done,
    output ack, ack_err, busy, grant_id, tx_start, tx_data
  );

  modport slave (
    output req, req_data, tx_done,
    input  ack, ack_err, busy, grant_id, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte requesters.
// Optional WAIT watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
`ifdef UART_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 ack_err_q, ack_err_d;
  logic                 busy_q, busy_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic                 tx_start_q, tx_start_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [IDX_W-1:0]     pick;
  logic [NUM_REQ-1:0]   ack_onehot;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // First set request strictly after 'last', wrapping; scanning k downwards
  // lets the smallest k overwrite, so it wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0]   sel;
    logic [NUM_REQ-1:0] rot;
    int                 idx;
    sel = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      rot = r >> idx;
      if (rot[0]) sel = IDX_W'(idx);
    end
    return sel;
  endfunction

  assign pick       = rr_pick(bus.req, last_q);
  assign ack_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;

  // NOTE: combinational next-state logic uses blocking '=' and gives every
  // target a default first, so no path leaves a variable unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    ack_d      = '0;
    ack_err_d  = 1'b0;
    busy_d     = busy_q;
    grant_d    = grant_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    last_d     = last_q;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d      = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          grant_d    = pick;
          tx_data_d  = 8'(bus.req_data >> (8 * int'(pick)));
          busy_d     = 1'b1;
          tx_start_d = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (bus.tx_done) begin
          ack_d   = ack_onehot;
          last_d  = grant_q;
          state_d = S_DONE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        // cnt_q counts completed WAIT cycles, so this is the TIMEOUT_CYCLES-th one.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          ack_d     = ack_onehot;
          ack_err_d = 1'b1;
          last_d    = grant_q;
          state_d   = S_DONE;
        end
`endif
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ack_q      <= '0;
      ack_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      grant_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      ack_err_q  <= ack_err_d;
      busy_q     <= busy_d;
      grant_q    <= grant_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      last_q     <= last_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign bus.ack      = ack_q;
  assign bus.ack_err  = ack_err_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;

endmodule
